// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the miniRV hazard controller:
// forward-select codes and sequencer state codes.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_MC_BUSY = 1'b1
  } state_t;

  function automatic logic rd_match(
    input logic [7:0] rd,
    input logic [7:0] rs,
    input logic       we,
    input logic       used
  );
    return used && we && (rd == rs) && (rd != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward select and load-use detect.
// Ports: rs/rs_used of the ID operand, rd/we/is_load
// of EX/MEM/WB; outputs sel (FWD_*) and load_hazard.
module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter bit LOAD_FWD_MEM = 1'b1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_we,
  input  logic              mem_we,
  input  logic              wb_we,
  input  logic              ex_is_load,
  input  logic              mem_is_load,
  output logic [1:0]        sel,
  output logic              load_hazard
);

  logic ex_m;
  logic mem_m;
  logic wb_m;
  logic mem_ok;

  assign ex_m  = rd_match(8'(ex_rd), 8'(rs),
                          ex_we, rs_used);
  assign mem_m = rd_match(8'(mem_rd), 8'(rs),
                          mem_we, rs_used);
  assign wb_m  = rd_match(8'(wb_rd), 8'(rs),
                          wb_we, rs_used);

  // load data only exists at the end of MEM
  assign mem_ok = LOAD_FWD_MEM || !mem_is_load;

  always_comb begin
    sel = FWD_RF;
    if (ex_m && !ex_is_load)
      sel = FWD_EX;
    else if (mem_m && mem_ok)
      sel = FWD_MEM;
    else if (wb_m)
      sel = FWD_WB;
  end

  assign load_hazard =
    (ex_m && ex_is_load) ||
    (mem_m && mem_is_load && !LOAD_FWD_MEM);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// miniRV hazard/sequencing controller: forwarding,
// load-use stalls, redirect flushes, multi-cycle
// handshake with watchdog, stall/flush counters.
// Ports: ID sources, EX/MEM/WB dest info, redirect,
// mc_op/mc_done in; stall/flush/bubble, fwd selects,
// mc_start, sticky mc_err, counters out.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter int MC_TIMEOUT   = 64,
  parameter bit LOAD_FWD_MEM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_we,
  input  logic              mem_we,
  input  logic              wb_we,
  input  logic              ex_is_load,
  input  logic              mem_is_load,
  input  logic              ex_redirect,
  input  logic              ex_mc_op,
  input  logic              mc_done,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_bubble,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic              mc_start,
  output logic              mc_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int TW =
    (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(MC_TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          just_done;

  logic rs1_haz;
  logic rs2_haz;
  logic lu_haz;
  logic busy;
  logic mc_go;
  logic tmo_hit;
  logic mc_end;

  hazard_fwd_sel #(
    .REG_AW      (REG_AW),
    .LOAD_FWD_MEM(LOAD_FWD_MEM)
  ) u_rs1 (
    .rs         (id_rs1),
    .rs_used    (id_rs1_used),
    .ex_rd      (ex_rd),
    .mem_rd     (mem_rd),
    .wb_rd      (wb_rd),
    .ex_we      (ex_we),
    .mem_we     (mem_we),
    .wb_we      (wb_we),
    .ex_is_load (ex_is_load),
    .mem_is_load(mem_is_load),
    .sel        (fwd_rs1_sel),
    .load_hazard(rs1_haz)
  );

  hazard_fwd_sel #(
    .REG_AW      (REG_AW),
    .LOAD_FWD_MEM(LOAD_FWD_MEM)
  ) u_rs2 (
    .rs         (id_rs2),
    .rs_used    (id_rs2_used),
    .ex_rd      (ex_rd),
    .mem_rd     (mem_rd),
    .wb_rd      (wb_rd),
    .ex_we      (ex_we),
    .mem_we     (mem_we),
    .wb_we      (wb_we),
    .ex_is_load (ex_is_load),
    .mem_is_load(mem_is_load),
    .sel        (fwd_rs2_sel),
    .load_hazard(rs2_haz)
  );

  assign lu_haz = rs1_haz || rs2_haz;
  assign busy   = (state == S_MC_BUSY);

  // the op still in EX right after completion is
  // the one that just finished; do not reissue it
  assign mc_go = (state == S_RUN) && ex_mc_op
              && !just_done;

  assign tmo_hit = busy && !mc_done
                && (tmo_cnt == TMO_LAST);
  assign mc_end  = busy && (mc_done || tmo_hit);

  // MC path outranks redirect; redirect squashes ID,
  // so it outranks load-use
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    if (mc_go) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (busy) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = !mc_end;
      exmem_bubble = !mc_end;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_haz) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      tmo_cnt   <= '0;
      just_done <= 1'b0;
      mc_start  <= 1'b0;
      mc_err    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mc_start  <= 1'b0;
      just_done <= 1'b0;
      unique case (state)
        S_RUN: begin
          if (mc_go) begin
            state    <= S_MC_BUSY;
            mc_start <= 1'b1;
            tmo_cnt  <= '0;
          end
        end
        S_MC_BUSY: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tmo_hit)
            mc_err <= 1'b1;
          if (mc_end) begin
            state     <= S_RUN;
            just_done <= 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
      if (pc_stall)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance
// (MEM load forwarding) and a second (WB only, MC_TIMEOUT 4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2;
  logic       id_rs1_used, id_rs2_used;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_we, mem_we, wb_we;
  logic       ex_is_load, mem_is_load;
  logic       ex_redirect, ex_mc_op, mc_done;

  logic        pc_stall, ifid_stall, idex_stall;
  logic        ifid_flush, idex_flush, exmem_bubble;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        mc_start, mc_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic        n_pc_stall, n_ifid_stall, n_idex_stall;
  logic        n_ifid_flush, n_idex_flush, n_exmem_bubble;
  logic [1:0]  n_fwd_rs1_sel, n_fwd_rs2_sel;
  logic        n_mc_start, n_mc_err;
  logic [31:0] n_stall_cnt, n_flush_cnt;

  int npass = 0;
  int ntot  = 0;
  int starts, stalls, bubbles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW(5), .CNT_W(32),
    .MC_TIMEOUT(64), .LOAD_FWD_MEM(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_is_load(ex_is_load),
    .mem_is_load(mem_is_load),
    .ex_redirect(ex_redirect),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble),
    .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel),
    .mc_start(mc_start), .mc_err(mc_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(
    .REG_AW(5), .CNT_W(32),
    .MC_TIMEOUT(4), .LOAD_FWD_MEM(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_is_load(ex_is_load),
    .mem_is_load(mem_is_load),
    .ex_redirect(ex_redirect),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done),
    .pc_stall(n_pc_stall),
    .ifid_stall(n_ifid_stall),
    .idex_stall(n_idex_stall),
    .ifid_flush(n_ifid_flush),
    .idex_flush(n_idex_flush),
    .exmem_bubble(n_exmem_bubble),
    .fwd_rs1_sel(n_fwd_rs1_sel),
    .fwd_rs2_sel(n_fwd_rs2_sel),
    .mc_start(n_mc_start), .mc_err(n_mc_err),
    .stall_cnt(n_stall_cnt),
    .flush_cnt(n_flush_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
    ex_is_load = 1'b0; mem_is_load = 1'b0;
    ex_redirect = 1'b0; ex_mc_op = 1'b0;
    mc_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_pc_stall", 32'(pc_stall), 0);
    chk("rst_bubble", 32'(exmem_bubble), 0);
    chk("rst_mc_start", 32'(mc_start), 0);
    chk("rst_mc_err", 32'(mc_err), 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_fwd1", 32'(fwd_rs1_sel), 0);

    // forwarding priority
    ex_rd = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
    ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1 chk("fwd_ex", 32'(fwd_rs1_sel), 1);
    ex_we = 1'b0;
    #1 chk("fwd_mem", 32'(fwd_rs1_sel), 2);
    mem_we = 1'b0;
    #1 chk("fwd_wb", 32'(fwd_rs1_sel), 3);
    id_rs1_used = 1'b0;
    #1 chk("fwd_unused", 32'(fwd_rs1_sel), 0);
    id_rs1_used = 1'b1; id_rs1 = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_we = 1'b1; mem_we = 1'b1;
    #1 chk("fwd_x0", 32'(fwd_rs1_sel), 0);
    ex_is_load = 1'b1;
    #1 chk("x0_no_stall", 32'(pc_stall), 0);
    idle();

    // load in MEM: main forwards, no-mem-fwd stalls
    mem_rd = 5'd9; mem_we = 1'b1; mem_is_load = 1'b1;
    id_rs2 = 5'd9; id_rs2_used = 1'b1;
    #1;
    chk("memld_sel", 32'(fwd_rs2_sel), 2);
    chk("memld_nostall", 32'(pc_stall), 0);
    chk("n_memld_sel", 32'(n_fwd_rs2_sel), 0);
    chk("n_memld_stall", 32'(n_pc_stall), 1);
    chk("n_memld_flush", 32'(n_idex_flush), 1);
    tick();
    chk("memld_cnt", stall_cnt, 0);
    chk("n_memld_cnt", n_stall_cnt, 1);
    idle();

    // load-use from EX
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7;
    id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #1;
    chk("lu_pc_stall", 32'(pc_stall), 1);
    chk("lu_ifid_stall", 32'(ifid_stall), 1);
    chk("lu_idex_flush", 32'(idex_flush), 1);
    chk("lu_ifid_flush", 32'(ifid_flush), 0);
    chk("lu_sel", 32'(fwd_rs2_sel), 0);
    tick();
    chk("lu_cnt", stall_cnt, 1);

    // redirect overrides load-use
    ex_redirect = 1'b1;
    #1;
    chk("rd_ifid_flush", 32'(ifid_flush), 1);
    chk("rd_idex_flush", 32'(idex_flush), 1);
    chk("rd_pc_stall", 32'(pc_stall), 0);
    chk("rd_ifid_stall", 32'(ifid_stall), 0);
    tick();
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_stall_cnt", stall_cnt, 1);
    idle();

    // multi-cycle handshake, done in 5th busy cycle
    do_reset();
    starts = 0; stalls = 0; bubbles = 0;
    for (int c = 0; c < 8; c++) begin
      ex_mc_op    = (c <= 6);
      mc_done     = (c == 5);
      ex_redirect = (c == 0);
      #1;
      starts  += int'(mc_start);
      stalls  += int'(pc_stall);
      bubbles += int'(exmem_bubble);
      if (c == 0)
        chk("mc_redir_ign", 32'(ifid_flush), 0);
      if (c == 1)
        chk("mc_start_c1", 32'(mc_start), 1);
      if (c == 5) begin
        chk("mc_done_idex", 32'(idex_stall), 0);
        chk("mc_done_bub", 32'(exmem_bubble), 0);
        chk("mc_done_pc", 32'(pc_stall), 1);
      end
      if (c == 6)
        chk("mc_no_reissue", 32'(pc_stall), 0);
      tick();
    end
    idle();
    chk("mc_starts", 32'(starts), 1);
    chk("mc_stalls", 32'(stalls), 6);
    chk("mc_bubbles", 32'(bubbles), 5);
    chk("mc_stall_cnt", stall_cnt, 6);
    chk("mc_flush_cnt", flush_cnt, 0);
    chk("mc_err_clean", 32'(mc_err), 0);

    // watchdog on the MC_TIMEOUT=4 instance
    do_reset();
    for (int c = 0; c < 7; c++) begin
      ex_mc_op = (c <= 5);
      #1;
      if (c == 4) begin
        chk("to_err_pre", 32'(n_mc_err), 0);
        chk("to_idex_adv", 32'(n_idex_stall), 0);
        chk("to_pc_hold", 32'(n_pc_stall), 1);
      end
      if (c == 5) begin
        chk("to_err", 32'(n_mc_err), 1);
        chk("to_run", 32'(n_pc_stall), 0);
      end
      tick();
    end
    idle();
    tick();
    tick();
    chk("to_sticky", 32'(n_mc_err), 1);
    chk("to_starts", 32'(n_mc_start), 0);
    do_reset();
    chk("to_rst_clr", 32'(n_mc_err), 0);

    // reset during the 2nd busy cycle
    ex_mc_op = 1'b1;
    tick();
    tick();
    #1;
    chk("mr_busy", 32'(pc_stall), 1);
    chk("mr_cnt_pre", stall_cnt, 2);
    ex_mc_op = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_pc_stall", 32'(pc_stall), 0);
    chk("mr_bubble", 32'(exmem_bubble), 0);
    chk("mr_start", 32'(mc_start), 0);
    chk("mr_err", 32'(mc_err), 0);
    chk("mr_stall_cnt", stall_cnt, 0);
    chk("mr_flush_cnt", flush_cnt, 0);
    tick();
    chk("mr_run", 32'(pc_stall), 0);
    chk("mr_no_start", 32'(mc_start), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
